glitc_bit_aligner: RTL and testbench

//  Automatic per-bit training aligner. Sits downstream of the dual-RITC datapath on
//  one channel's 48-bit SYSCLK word (12 bits x 4 samples). It captures 8-bit training

---
 rtl/glitc_bit_aligner.sv | 172 +++++++++++++++++
 tb/tb_glitc_bit_aligner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_bit_aligner.sv
// Per-bit training aligner: captures 8-bit frames on one channel bit,
// compares them to the expected byte and issues BITSLIPs until lock or failure.
module glitc_bit_aligner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int MATCH_FRAMES  = 4,
  parameter int MAX_SLIPS     = 8
) (
  input  logic        SYSCLK,
  input  logic        rst_i,
  input  logic [47:0] data_i,
  input  logic        valid_i,
  input  logic        sync_i,
  input  logic        start_i,
  input  logic [3:0]  bit_sel_i,
  input  logic [7:0]  pattern_i,
  output logic [11:0] bitslip_o,
  output logic        busy_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic [3:0]  slip_count_o,
  output logic [7:0]  frame_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_FRAMES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_FRAMES - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CAP_HI, S_CAP_LO,
    S_CHECK, S_SLIP, S_LOCK, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    pat_q, pat_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    frame_q, frame_d;
  logic [3:0]    slip_q, slip_d;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic [3:0]    nib;

  // Selected bit's 4 samples; out-of-range selects never reach capture.
  always_comb begin
    nib = '0;
    for (int b = 0; b < 12; b++) begin
      if (sel_q == b[3:0]) nib = data_i[4*b +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pat_d    = pat_q;
    cap_d    = cap_q;
    frame_d  = frame_q;
    slip_d   = slip_q;
    match_d  = match_q;
    settle_d = settle_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d    = bit_sel_i;
          pat_d    = pattern_i;
          slip_d   = '0;
          locked_d = 1'b0;
          fail_d   = 1'b0;
          settle_d = '0;
          match_d  = '0;
          if (bit_sel_i > 4'd11) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (valid_i) begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = S_CAP_HI;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
      end
      S_CAP_HI: begin
        if (valid_i && sync_i) begin
          cap_d[7:4] = nib;
          state_d    = S_CAP_LO;
        end
      end
      S_CAP_LO: begin
        if (valid_i) begin
          if (sync_i) begin
            cap_d[7:4] = nib;
          end else begin
            cap_d[3:0] = nib;
            state_d    = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        frame_d = cap_q;
        if (cap_q == pat_q) begin
          if (match_q == MATCH_LAST) begin
            state_d  = S_LOCK;
            locked_d = 1'b1;
          end else begin
            match_d = match_q + MW'(1);
            state_d = S_CAP_HI;
          end
        end else if (slip_q < SLIP_MAX) begin
          state_d = S_SLIP;
        end else begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end
      end
      S_SLIP: begin
        if (slip_q < SLIP_MAX) slip_d = slip_q + 4'd1;
        match_d  = '0;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_LOCK:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      pat_q    <= '0;
      cap_q    <= '0;
      frame_q  <= '0;
      slip_q   <= '0;
      match_q  <= '0;
      settle_q <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pat_q    <= pat_d;
      cap_q    <= cap_d;
      frame_q  <= frame_d;
      slip_q   <= slip_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign bitslip_o = (state_q == S_SLIP) ? (12'd1 << sel_q) : '0;
  assign busy_o = !(state_q inside {S_IDLE, S_LOCK, S_FAIL});
  assign locked_o     = locked_q;
  assign fail_o       = fail_q;
  assign slip_count_o = slip_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_glitc_bit_aligner.sv
// Bench for glitc_bit_aligner: serial-source model with bitslip rotation,
// per-cycle scoreboard of slip pulses plus directed run outcomes.
module tb_glitc_bit_aligner;

  localparam int SETTLE = 16;
  localparam int MAXS   = 8;

  logic        SYSCLK = 1'b0;
  logic        rst_i;
  logic [47:0] data_i;
  logic        valid_i;
  logic        sync_i;
  logic        start_i;
  logic [3:0]  bit_sel_i;
  logic [7:0]  pattern_i;
  logic [11:0] bitslip_o;
  logic        busy_o;
  logic        locked_o;
  logic        fail_o;
  logic [3:0]  slip_count_o;
  logic [7:0]  frame_o;

  always #5 SYSCLK = ~SYSCLK;

  glitc_bit_aligner dut (
    .SYSCLK      (SYSCLK),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sync_i      (sync_i),
    .start_i     (start_i),
    .bit_sel_i   (bit_sel_i),
    .pattern_i   (pattern_i),
    .bitslip_o   (bitslip_o),
    .busy_o      (busy_o),
    .locked_o    (locked_o),
    .fail_o      (fail_o),
    .slip_count_o(slip_count_o),
    .frame_o     (frame_o)
  );

  int checks = 0;
  int errors = 0;

  // source model: byte seen by the receiver is the pattern rotated by offset;
  // every bitslip on the selected bit advances the rotation by one.
  int         src_mode;
  int         src_sel;
  int         offset;
  logic [7:0] src_pat;
  logic [7:0] cur_byte;
  bit         phase;
  bit         gen_valid;

  // scoreboard state
  bit mon_on = 0;
  int cyc;
  int exp_sel;
  int m_cnt;
  int last_pulse;
  int n;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic drive();
    logic [63:0] r64;
    logic [47:0] w;
    logic [3:0]  nb;
    logic [7:0]  g;
    if (src_sel >= 0 && src_sel < 12) begin
      if (bitslip_o[src_sel]) offset = (offset + 1) % 8;
    end
    r64 = {$urandom, $urandom};
    w = r64[47:0];
    if (gen_valid) begin
      if (!phase) begin
        if (src_mode == 0) begin
          cur_byte = rotl(src_pat, offset);
        end else begin
          g = 8'($urandom_range(0, 255));
          if (g == src_pat) g = g ^ 8'h01;
          cur_byte = g;
        end
        nb = cur_byte[7:4];
        sync_i = 1'b1;
      end else begin
        nb = cur_byte[3:0];
        sync_i = 1'b0;
      end
      phase = ~phase;
      valid_i = 1'b1;
      if (src_sel >= 0 && src_sel < 12) w[4*src_sel +: 4] = nb;
    end else begin
      valid_i = 1'b0;
      sync_i = 1'($urandom_range(0, 1));
    end
    data_i = w;
  endtask

  task automatic monitor();
    bit legal;
    if (!mon_on) return;
    cyc++;
    legal = (bitslip_o == 12'd0) ||
            (exp_sel < 12 && bitslip_o == (12'd1 << exp_sel));
    chk("bitslip_target", int'(legal), 1);
    chk("slip_count", int'(slip_count_o), (m_cnt > MAXS) ? MAXS : m_cnt);
    chk("lock_fail_excl", int'(locked_o & fail_o), 0);
    chk("busy_when_done", int'(busy_o & (locked_o | fail_o)), 0);
    if (bitslip_o != 12'd0) begin
      if (last_pulse >= 0)
        chk("slip_spacing", int'((cyc - last_pulse) >= SETTLE + 3), 1);
      last_pulse = cyc;
      m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
    start_i = 1'b0;
    rst_i = 1'b0;
    drive();
    @(negedge SYSCLK);
    monitor();
  endtask

  task automatic start_run(input int sel, input logic [7:0] pat,
                           input int mode, input int off);
    m_cnt = 0;
    last_pulse = -1;
    exp_sel = sel;
    src_sel = sel;
    src_pat = pat;
    src_mode = mode;
    offset = off;
    phase = 1'b0;
    gen_valid = 1'b1;
    start_i = 1'b1;
    bit_sel_i = sel[3:0];
    pattern_i = pat;
    drive();
    tick();
  endtask

  task automatic wait_done(input int budget, input int pa, input int pl,
                           output int cnt);
    bit done;
    cnt = 0;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (!busy_o) begin
        done = 1;
      end else begin
        cnt++;
        if (cnt == pa) gen_valid = 1'b0;
        if (cnt == pa + pl) gen_valid = 1'b1;
        tick();
      end
    end
    if (!done) chk("run_timeout", int'(busy_o), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    bit_sel_i = '0;
    pattern_i = '0;
    data_i = '0;
    valid_i = 1'b0;
    sync_i = 1'b0;
    src_sel = -1;
    src_mode = 0;
    src_pat = '0;
    offset = 0;
    phase = 1'b0;
    gen_valid = 1'b0;
    cur_byte = '0;
    cyc = 0;
    exp_sel = 99;
    m_cnt = 0;
    last_pulse = -1;
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    chk("rst_bitslip", int'(bitslip_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_fail", int'(fail_o), 0);
    chk("rst_count", int'(slip_count_o), 0);
    chk("rst_frame", int'(frame_o), 0);
    mon_on = 1;
    tick();

    // 1: aligned source on bit 3
    start_run(3, 8'hA5, 0, 0);
    wait_done(400, -1, 0, n);
    chk("t1_duration", n, 32);
    chk("t1_locked", int'(locked_o), 1);
    chk("t1_fail", int'(fail_o), 0);
    chk("t1_count", int'(slip_count_o), 0);
    chk("t1_pulses", m_cnt, 0);
    chk("t1_frame", int'(frame_o), 'hA5);
    tick();

    // 2: rotated by 6 -> two slips to reach 0xA5 on bit 7
    start_run(7, 8'hA5, 0, 6);
    wait_done(600, -1, 0, n);
    chk("t2_locked", int'(locked_o), 1);
    chk("t2_fail", int'(fail_o), 0);
    chk("t2_count", int'(slip_count_o), 2);
    chk("t2_pulses", m_cnt, 2);
    chk("t2_frame", int'(frame_o), 'hA5);
    tick();

    // 3: garbage never matches
    start_run(5, 8'h3C, 1, 0);
    wait_done(3000, -1, 0, n);
    chk("t3_fail", int'(fail_o), 1);
    chk("t3_locked", int'(locked_o), 0);
    chk("t3_count", int'(slip_count_o), 8);
    chk("t3_pulses", m_cnt, 8);
    chk("t3_frame_ne", int'(frame_o != 8'h3C), 1);
    tick();

    // 4: illegal bit select
    start_run(13, 8'hA5, 0, 0);
    if (!fail_o) tick();
    chk("t4_fail", int'(fail_o), 1);
    chk("t4_count", int'(slip_count_o), 0);
    repeat (5) tick();
    chk("t4_busy", int'(busy_o), 0);
    chk("t4_pulses", m_cnt, 0);

    // 5: 50 invalid cycles mid-SETTLE stretch the run by exactly 50
    start_run(2, 8'hC3, 0, 0);
    wait_done(600, 5, 50, n);
    chk("t5_duration", n, 82);
    chk("t5_locked", int'(locked_o), 1);
    chk("t5_count", int'(slip_count_o), 0);
    chk("t5_frame", int'(frame_o), 'hC3);
    tick();

    // 6: reset during SETTLE after one slip, then a clean run
    start_run(7, 8'hA5, 0, 6);
    for (int i = 0; i < 200 && m_cnt < 1; i++) tick();
    chk("t6_first_slip", m_cnt, 1);
    repeat (3) tick();
    rst_i = 1'b1;
    m_cnt = 0;
    last_pulse = -1;
    exp_sel = 99;
    tick();
    chk("t6_rst_bitslip", int'(bitslip_o), 0);
    chk("t6_rst_busy", int'(busy_o), 0);
    chk("t6_rst_locked", int'(locked_o), 0);
    chk("t6_rst_fail", int'(fail_o), 0);
    chk("t6_rst_count", int'(slip_count_o), 0);
    chk("t6_rst_frame", int'(frame_o), 0);
    repeat (40) tick();
    chk("t6_no_pulse", m_cnt, 0);
    start_run(1, 8'h3C, 0, 0);
    wait_done(400, -1, 0, n);
    chk("t6_duration", n, 32);
    chk("t6_locked", int'(locked_o), 1);
    chk("t6_count", int'(slip_count_o), 0);
    chk("t6_frame", int'(frame_o), 'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
